// File: rtl/sort_pkg.sv
// Shared types and constants for the sort engine and its compare-exchange cell.
package sort_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Sort direction encodings as carried on in_desc.
  localparam logic SORT_ASC  = 1'b0;
  localparam logic SORT_DESC = 1'b1;

endpackage

// File: rtl/sort_cmp_xchg.sv
// Combinational compare-exchange cell: orders one key/index pair.
// Keys move together with their indices. Equal keys never swap, which keeps
// the network stable.
module sort_cmp_xchg
  import sort_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  lo_key_i,
  input  logic [W-1:0]  hi_key_i,
  input  logic [IW-1:0] lo_idx_i,
  input  logic [IW-1:0] hi_idx_i,
  input  logic          desc,
  output logic [W-1:0]  lo_key_o,
  output logic [W-1:0]  hi_key_o,
  output logic [IW-1:0] lo_idx_o,
  output logic [IW-1:0] hi_idx_o
);

  logic swap;

  // Swap only when the pair is strictly out of order (unsigned compare).
  always_comb begin
    swap     = (desc == SORT_DESC) ? (lo_key_i < hi_key_i) : (lo_key_i > hi_key_i);
    lo_key_o = swap ? hi_key_i : lo_key_i;
    hi_key_o = swap ? lo_key_i : hi_key_i;
    lo_idx_o = swap ? hi_idx_i : lo_idx_i;
    hi_idx_o = swap ? lo_idx_i : hi_idx_i;
  end

endmodule

// File: rtl/sort_engine.sv
// Handshaked odd-even transposition sorter. One network phase per cycle,
// N phases per job, then one cycle to publish keys and original lane indices.
module sort_engine
  import sort_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int W  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [N*IW-1:0] out_idx,
  output logic            busy
);

  localparam int PW    = $clog2(N + 1);
  localparam int NE    = N / 2;
  localparam int NO    = (N - 1) / 2;
  localparam int NO_SZ = (NO > 0) ? NO : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [W-1:0]    key_q [N];
  logic [W-1:0]    key_d [N];
  logic [IW-1:0]   idx_q [N];
  logic [IW-1:0]   idx_d [N];
  logic            desc_q, desc_d;
  logic            out_valid_q, out_valid_d;
  logic [N*W-1:0]  out_data_q, out_data_d;
  logic [N*IW-1:0] out_idx_q, out_idx_d;

  // Cell results for even phases: pairs (2k, 2k+1).
  logic [W-1:0]  ev_key_lo [NE];
  logic [W-1:0]  ev_key_hi [NE];
  logic [IW-1:0] ev_idx_lo [NE];
  logic [IW-1:0] ev_idx_hi [NE];

  // Cell results for odd phases: pairs (2k+1, 2k+2).
  logic [W-1:0]  od_key_lo [NO_SZ];
  logic [W-1:0]  od_key_hi [NO_SZ];
  logic [IW-1:0] od_idx_lo [NO_SZ];
  logic [IW-1:0] od_idx_hi [NO_SZ];

  // Array after applying the current phase.
  logic [W-1:0]  ph_key [N];
  logic [IW-1:0] ph_idx [N];

  genvar gi;

  generate
    for (gi = 0; gi < NE; gi++) begin : g_even
      sort_cmp_xchg #(.W(W), .IW(IW)) u_cell (
        .lo_key_i (key_q[2*gi]),
        .hi_key_i (key_q[2*gi+1]),
        .lo_idx_i (idx_q[2*gi]),
        .hi_idx_i (idx_q[2*gi+1]),
        .desc     (desc_q),
        .lo_key_o (ev_key_lo[gi]),
        .hi_key_o (ev_key_hi[gi]),
        .lo_idx_o (ev_idx_lo[gi]),
        .hi_idx_o (ev_idx_hi[gi])
      );
    end

    for (gi = 0; gi < NO; gi++) begin : g_odd
      sort_cmp_xchg #(.W(W), .IW(IW)) u_cell (
        .lo_key_i (key_q[2*gi+1]),
        .hi_key_i (key_q[2*gi+2]),
        .lo_idx_i (idx_q[2*gi+1]),
        .hi_idx_i (idx_q[2*gi+2]),
        .desc     (desc_q),
        .lo_key_o (od_key_lo[gi]),
        .hi_key_o (od_key_hi[gi]),
        .lo_idx_o (od_idx_lo[gi]),
        .hi_idx_o (od_idx_hi[gi])
      );
    end

    // With N=2 there are no odd pairs; tie off the single unused slot.
    if (NO == 0) begin : g_no_odd
      assign od_key_lo[0] = '0;
      assign od_key_hi[0] = '0;
      assign od_idx_lo[0] = '0;
      assign od_idx_hi[0] = '0;
    end
  endgenerate

  // Select even or odd cell results by phase parity; unpaired lanes hold.
  always_comb begin
    ph_key = key_q;
    ph_idx = idx_q;
    if (!phase_q[0]) begin
      for (int k = 0; k < NE; k++) begin
        ph_key[2*k]   = ev_key_lo[k];
        ph_key[2*k+1] = ev_key_hi[k];
        ph_idx[2*k]   = ev_idx_lo[k];
        ph_idx[2*k+1] = ev_idx_hi[k];
      end
    end else begin
      for (int k = 0; k < NO; k++) begin
        ph_key[2*k+1] = od_key_lo[k];
        ph_key[2*k+2] = od_key_hi[k];
        ph_idx[2*k+1] = od_idx_lo[k];
        ph_idx[2*k+2] = od_idx_hi[k];
      end
    end
  end

  // Next-state logic: job load, one phase per SORT cycle, publish, hold.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    key_d       = key_q;
    idx_d       = idx_q;
    desc_d      = desc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N; i++) begin
            key_d[i] = in_data[i*W +: W];
            idx_d[i] = IW'(i);
          end
          desc_d  = in_desc;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        if (phase_q == PW'(N)) begin
          // All phases done: this cycle only copies the array out.
          for (int i = 0; i < N; i++) begin
            out_data_d[i*W +: W]   = key_q[i];
            out_idx_d[i*IW +: IW]  = idx_q[i];
          end
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          key_d   = ph_key;
          idx_d   = ph_idx;
          phase_d = phase_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      desc_q      <= SORT_ASC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int i = 0; i < N; i++) begin
        key_q[i] <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      desc_q      <= desc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      key_q       <= key_d;
      idx_q       <= idx_d;
    end
  end

  // in_ready is held low while reset is asserted, even though state reads IDLE.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine with three instances: N=4/W=8, N=8/W=8, N=5/W=12.
module tb_sort_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // N=4, W=8
  logic        iv4, ir4, id4, ov4, or4, busy4;
  logic [31:0] in_data4, out_data4;
  logic [7:0]  out_idx4;
  // N=8, W=8
  logic        iv8, ir8, id8, ov8, or8, busy8;
  logic [63:0] in_data8, out_data8;
  logic [23:0] out_idx8;
  // N=5, W=12
  logic        iv5, ir5, id5, ov5, or5, busy5;
  logic [59:0] in_data5, out_data5;
  logic [14:0] out_idx5;

  sort_engine #(.N(4), .W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_data(in_data4),
    .in_desc(id4), .out_valid(ov4), .out_ready(or4), .out_data(out_data4),
    .out_idx(out_idx4), .busy(busy4));

  sort_engine #(.N(8), .W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(in_data8),
    .in_desc(id8), .out_valid(ov8), .out_ready(or8), .out_data(out_data8),
    .out_idx(out_idx8), .busy(busy8));

  sort_engine #(.N(5), .W(12)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .in_data(in_data5),
    .in_desc(id5), .out_valid(ov5), .out_ready(or5), .out_data(out_data5),
    .out_idx(out_idx5), .busy(busy5));

  // Offer one job, return the number of edges from accept to out_valid.
  task automatic job4(input logic [31:0] d, input logic desc, output int edges);
    @(negedge clk);
    iv4 = 1'b1; in_data4 = d; id4 = desc; or4 = 1'b0;
    @(posedge clk); #1;
    iv4 = 1'b0; in_data4 = ~d; id4 = ~desc;  // post-accept changes must not matter
    edges = 0;
    while (!ov4 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic job8(input logic [63:0] d, input logic desc, output int edges);
    @(negedge clk);
    iv8 = 1'b1; in_data8 = d; id8 = desc; or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0; in_data8 = ~d; id8 = ~desc;
    edges = 0;
    while (!ov8 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic job5(input logic [59:0] d, input logic desc, output int edges);
    @(negedge clk);
    iv5 = 1'b1; in_data5 = d; id5 = desc; or5 = 1'b0;
    @(posedge clk); #1;
    iv5 = 1'b0; in_data5 = ~d; id5 = ~desc;
    edges = 0;
    while (!ov5 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    iv4 = 0; id4 = 0; or4 = 0; in_data4 = '0;
    iv8 = 0; id8 = 0; or8 = 0; in_data8 = '0;
    iv5 = 0; id5 = 0; or5 = 0; in_data5 = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (ir4 !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %b want 0", ir4); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if (ir4 !== 1'b1) begin errors++; $display("FAIL rst_ready4 got %b want 1", ir4); end
    checks++; if (ov4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL rst_valid_busy4 got %b%b want 00", ov4, busy4); end
    checks++; if (out_data4 !== 32'h0 || out_idx4 !== 8'h0) begin errors++; $display("FAIL rst_outs4 got %h/%h want 0/0", out_data4, out_idx4); end
    checks++; if (ir8 !== 1'b1 || ir5 !== 1'b1) begin errors++; $display("FAIL rst_ready85 got %b%b want 11", ir8, ir5); end
    $display("reset: done");
  endtask

  task automatic test_ascending();
    int e;
    job4({8'h20, 8'h40, 8'h10, 8'h30}, 1'b0, e);
    checks++; if (e !== 5) begin errors++; $display("FAIL asc_latency got %0d want 5", e); end
    checks++; if (out_data4 !== {8'h40, 8'h30, 8'h20, 8'h10}) begin errors++; $display("FAIL asc_data got %h want 40302010", out_data4); end
    checks++; if (out_idx4 !== {2'd2, 2'd0, 2'd3, 2'd1}) begin errors++; $display("FAIL asc_idx got %h want %h", out_idx4, {2'd2, 2'd0, 2'd3, 2'd1}); end
    checks++; if (busy4 !== 1'b1 || ir4 !== 1'b0) begin errors++; $display("FAIL asc_hold_flags got busy=%b ready=%b want 1/0", busy4, ir4); end
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL asc_release got %b want 0", ov4); end
    $display("ascending: latency=%0d data=%h idx=%h", e, out_data4, out_idx4);
  endtask

  task automatic test_descending();
    int e;
    job4({8'h20, 8'h40, 8'h10, 8'h30}, 1'b1, e);
    checks++; if (out_data4 !== {8'h10, 8'h20, 8'h30, 8'h40}) begin errors++; $display("FAIL desc_data got %h want 10203040", out_data4); end
    checks++; if (out_idx4 !== {2'd1, 2'd3, 2'd0, 2'd2}) begin errors++; $display("FAIL desc_idx got %h want %h", out_idx4, {2'd1, 2'd3, 2'd0, 2'd2}); end
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    $display("descending: data=%h idx=%h", out_data4, out_idx4);
  endtask

  task automatic test_stability();
    int e;
    job4({8'h05, 8'hFF, 8'h05, 8'h05}, 1'b0, e);
    checks++; if (out_data4 !== {8'hFF, 8'h05, 8'h05, 8'h05}) begin errors++; $display("FAIL stab_data got %h want ff050505", out_data4); end
    checks++; if (out_idx4 !== {2'd2, 2'd3, 2'd1, 2'd0}) begin errors++; $display("FAIL stab_idx got %h want %h", out_idx4, {2'd2, 2'd3, 2'd1, 2'd0}); end
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    $display("stability: data=%h idx=%h", out_data4, out_idx4);
  endtask

  task automatic test_backpressure();
    int e;
    int bad;
    job4({8'h20, 8'h40, 8'h10, 8'h30}, 1'b0, e);
    iv4 = 1'b1; in_data4 = {8'h01, 8'h02, 8'h03, 8'h04}; id4 = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_data4 !== {8'h40, 8'h30, 8'h20, 8'h10} || out_idx4 !== {2'd2, 2'd0, 2'd3, 2'd1} ||
          ir4 !== 1'b0 || ov4 !== 1'b1) begin
        errors++; bad++;
        $display("FAIL bp_hold cycle %0d got data=%h idx=%h ready=%b valid=%b want 40302010/%h/0/1",
                 c, out_data4, out_idx4, ir4, ov4, {2'd2, 2'd0, 2'd3, 2'd1});
      end
    end
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    checks++; if (ov4 !== 1'b0 || ir4 !== 1'b1) begin errors++; $display("FAIL bp_gap got valid=%b ready=%b want 0/1", ov4, ir4); end
    @(posedge clk); #1;
    iv4 = 1'b0;
    checks++; if (ir4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL bp_accept2 got ready=%b busy=%b want 0/1", ir4, busy4); end
    e = 0;
    while (!ov4 && e < 100) begin @(posedge clk); #1; e++; end
    checks++; if (e !== 5) begin errors++; $display("FAIL bp_latency2 got %0d want 5", e); end
    checks++; if (out_data4 !== 32'h04030201 || out_idx4 !== {2'd0, 2'd1, 2'd2, 2'd3}) begin
      errors++; $display("FAIL bp_job2 got %h/%h want 04030201/%h", out_data4, out_idx4, {2'd0, 2'd1, 2'd2, 2'd3});
    end
    or4 = 1'b1; @(posedge clk); #1; or4 = 1'b0;
    $display("backpressure: hold_errors=%0d job2=%h", bad, out_data4);
  endtask

  task automatic test_back_to_back();
    int a0, a1;
    logic [31:0] cap_a, cap_b;
    logic [7:0]  cap_bi;
    a0 = -1; a1 = -1; cap_a = '0; cap_b = '0; cap_bi = '0;
    @(negedge clk);
    iv4 = 1'b1; or4 = 1'b1; id4 = 1'b0; in_data4 = {8'h20, 8'h40, 8'h10, 8'h30};
    for (int c = 0; c < 40; c++) begin
      if (ir4 && iv4) begin
        if (a0 < 0) a0 = c; else a1 = c;
      end
      if (ov4 && a1 < 0) cap_a = out_data4;
      if (ov4 && a1 >= 0) begin cap_b = out_data4; cap_bi = out_idx4; end
      @(posedge clk); #1;
      if (a0 >= 0 && a1 < 0) in_data4 = {8'hAA, 8'h00, 8'hAA, 8'h01};
      if (a1 >= 0) iv4 = 1'b0;
      @(negedge clk);
    end
    or4 = 1'b0; iv4 = 1'b0;
    checks++; if (a1 - a0 !== 7) begin errors++; $display("FAIL b2b_interval got %0d want 7", a1 - a0); end
    checks++; if (cap_a !== 32'h40302010) begin errors++; $display("FAIL b2b_job1 got %h want 40302010", cap_a); end
    checks++; if (cap_b !== {8'hAA, 8'hAA, 8'h01, 8'h00} || cap_bi !== {2'd3, 2'd1, 2'd0, 2'd2}) begin
      errors++; $display("FAIL b2b_job2 got %h/%h want aaaa0100/%h", cap_b, cap_bi, {2'd3, 2'd1, 2'd0, 2'd2});
    end
    $display("back_to_back: interval=%0d job1=%h job2=%h", a1 - a0, cap_a, cap_b);
  endtask

  task automatic test_reset_mid();
    int e;
    logic [63:0] keys;
    keys = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    job8(keys, 1'b0, e);
    checks++; if (out_data8 !== 64'h0706050403020100) begin errors++; $display("FAIL mid_pre_data got %h want 0706050403020100", out_data8); end
    or8 = 1'b1; @(posedge clk); #1; or8 = 1'b0;
    // Second job, interrupted at phase 2.
    @(negedge clk);
    iv8 = 1'b1; in_data8 = keys; id8 = 1'b1;
    @(posedge clk); #1; iv8 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b0) begin
      errors++; $display("FAIL mid_during got valid=%b busy=%b ready=%b want 0/0/0", ov8, busy8, ir8);
    end
    checks++; if (out_data8 !== 64'h0 || out_idx8 !== 24'h0) begin errors++; $display("FAIL mid_outs got %h/%h want 0/0", out_data8, out_idx8); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (ov8 !== 1'b0 || busy8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++; $display("FAIL mid_after got valid=%b busy=%b ready=%b want 0/0/1", ov8, busy8, ir8);
    end
    e = 0;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (ov8) e++; end
    checks++; if (e !== 0) begin errors++; $display("FAIL mid_no_replay got %0d valid cycles want 0", e); end
    job8(keys, 1'b0, e);
    checks++; if (e !== 9) begin errors++; $display("FAIL mid_latency got %0d want 9", e); end
    checks++; if (out_data8 !== 64'h0706050403020100) begin errors++; $display("FAIL mid_data got %h want 0706050403020100", out_data8); end
    checks++; if (out_idx8 !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}) begin
      errors++; $display("FAIL mid_idx got %h want %h", out_idx8, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
    end
    or8 = 1'b1; @(posedge clk); #1; or8 = 1'b0;
    $display("reset_mid: data=%h idx=%h", out_data8, out_idx8);
  endtask

  task automatic test_odd_depth();
    int e;
    job5({12'h400, 12'h001, 12'hFFF, 12'h001, 12'h800}, 1'b0, e);
    checks++; if (e !== 6) begin errors++; $display("FAIL odd_latency got %0d want 6", e); end
    checks++; if (out_data5 !== {12'hFFF, 12'h800, 12'h400, 12'h001, 12'h001}) begin
      errors++; $display("FAIL odd_data got %h want %h", out_data5, {12'hFFF, 12'h800, 12'h400, 12'h001, 12'h001});
    end
    checks++; if (out_idx5 !== {3'd2, 3'd0, 3'd4, 3'd3, 3'd1}) begin
      errors++; $display("FAIL odd_idx got %h want %h", out_idx5, {3'd2, 3'd0, 3'd4, 3'd3, 3'd1});
    end
    or5 = 1'b1; @(posedge clk); #1; or5 = 1'b0;
    $display("odd_depth: data=%h idx=%h", out_data5, out_idx5);
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_stability();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_odd_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
